// File: rtl/frame_mux_rr.sv
// frame_mux_rr: round-robin merge of N_CH length-delimited ingress FIFO frames into one egress FIFO.
// Optional build macro FRAME_MUX_HEADER_EN prefixes each frame with a {HDR_TAG, channel} header word.
module frame_mux_rr #(
    parameter int unsigned   N_CH    = 6,
    parameter int unsigned   DW      = 16,
    parameter int unsigned   LEN_W   = 16,
    parameter logic [DW-9:0] HDR_TAG = 'hA5,
    localparam int unsigned  CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  init_clk,
    input  logic                  reset_n_i,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH*LEN_W-1:0] frame_words,
    output logic [N_CH-1:0]       ingress_fifo_rd_en,
    input  logic [N_CH*DW-1:0]    ingress_fifo_out,
    input  logic [N_CH-1:0]       ingress_fifo_empty,
    output logic [DW-1:0]         egress_fifo_din,
    output logic                  egress_fifo_wren,
    input  logic                  egress_fifo_full,
    output logic [CH_W-1:0]       cur_ch,
    output logic                  busy,
    output logic                  frame_done,
    output logic [31:0]           frame_cnt
);

    typedef enum logic [2:0] {IDLE, SEL, HDR, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_a  [N_CH];
    logic [DW-1:0]     data_a [N_CH];
    logic [LEN_W-1:0]  remaining_q;
    logic              served_q;
    logic [CH_W-1:0]   start_c, cand_c, sel_idx_c;
    logic              sel_found_c;
    logic [N_CH-1:0]   rd_en_c;
    logic              rd_go_c, load_c, hdr_go_c, busy_d;
    logic [DW-1:0]     hdr_word_c;
    logic              rd_q, last_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign len_a[k]  = frame_words[k*LEN_W +: LEN_W];
        assign data_a[k] = ingress_fifo_out[k*DW +: DW];
    end

`ifdef FRAME_MUX_HEADER_EN
    assign hdr_word_c = {HDR_TAG, 8'(cur_ch)};
`else
    logic [DW-1:0] unused_hdr_tag;
    assign unused_hdr_tag = {HDR_TAG, 8'h00};
    assign hdr_word_c     = '0;
`endif

    // Search origin: channel 0 until something has been served, then the one after last served.
    always_comb begin
        start_c = '0;
        if (served_q) begin
            start_c = (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + CH_W'(1);
        end
    end

    // First qualifying channel at or after start_c, wrapping.
    always_comb begin
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        cand_c      = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cand_c = CH_W'((32'(start_c) + 32'(i)) % N_CH);
            if (!sel_found_c && ch_en[cand_c] && (len_a[cand_c] != '0)) begin
                sel_found_c = 1'b1;
                sel_idx_c   = cand_c;
            end
        end
    end

    always_ff @(posedge init_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_en_c  = '0;
        rd_go_c  = 1'b0;
        load_c   = 1'b0;
        hdr_go_c = 1'b0;
        case (state_q)
            IDLE: state_d = SEL;
            SEL: begin
                if (sel_found_c) begin
                    load_c = 1'b1;
`ifdef FRAME_MUX_HEADER_EN
                    state_d = HDR;
`else
                    state_d = READ;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
`ifdef FRAME_MUX_HEADER_EN
                if (!egress_fifo_full) begin
                    hdr_go_c = 1'b1;
                    state_d  = READ;
                end
`else
                state_d = READ;
`endif
            end
            READ: begin
                if (!ingress_fifo_empty[cur_ch] && !egress_fifo_full && (remaining_q != '0)) begin
                    rd_go_c          = 1'b1;
                    rd_en_c[cur_ch]  = 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!rd_q) begin
                    state_d = SEL;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == HDR) || (state_d == READ) || (state_d == DRAIN);
    end

    assign ingress_fifo_rd_en = rd_en_c;

    // Frame bookkeeping: served channel and words left to read.
    always_ff @(posedge init_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cur_ch      <= '0;
            served_q    <= 1'b0;
            remaining_q <= '0;
            busy        <= 1'b0;
        end else begin
            busy <= busy_d;
            if (load_c) begin
                cur_ch      <= sel_idx_c;
                served_q    <= 1'b1;
                remaining_q <= len_a[sel_idx_c];
            end else if (rd_go_c) begin
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

    // Egress pipeline: ingress data is valid one cycle after rd_en and is registered out.
    always_ff @(posedge init_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_q             <= 1'b0;
            last_q           <= 1'b0;
            egress_fifo_din  <= '0;
            egress_fifo_wren <= 1'b0;
            frame_done       <= 1'b0;
            frame_cnt        <= '0;
        end else begin
            rd_q       <= rd_go_c;
            last_q     <= rd_go_c && (remaining_q == LEN_W'(1));
            frame_done <= rd_q && last_q;
            if (rd_q && last_q) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if (rd_q) begin
                egress_fifo_din  <= data_a[cur_ch];
                egress_fifo_wren <= 1'b1;
            end else if (hdr_go_c) begin
                egress_fifo_din  <= hdr_word_c;
                egress_fifo_wren <= 1'b1;
            end else begin
                egress_fifo_din  <= '0;
                egress_fifo_wren <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_mux_rr.sv
// tb_frame_mux_rr: random stimulus against a frame-level round-robin reference model.
// Honors FRAME_MUX_HEADER_EN the same way as the design.
module tb_frame_mux_rr;
    localparam int N     = 6;
    localparam int DW    = 16;
    localparam int LEN_W = 16;
    localparam int CH_W  = 3;
`ifdef FRAME_MUX_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic              init_clk = 1'b0;
    logic              reset_n_i;
    logic [N-1:0]      ch_en;
    logic [N*LEN_W-1:0] frame_words;
    logic [N-1:0]      ingress_fifo_rd_en;
    logic [N*DW-1:0]   ingress_fifo_out;
    logic [N-1:0]      ingress_fifo_empty;
    logic [DW-1:0]     egress_fifo_din;
    logic              egress_fifo_wren;
    logic              egress_fifo_full;
    logic [CH_W-1:0]   cur_ch;
    logic              busy;
    logic              frame_done;
    logic [31:0]       frame_cnt;

    always #5 init_clk = ~init_clk;

    frame_mux_rr dut (
        .init_clk           (init_clk),
        .reset_n_i          (reset_n_i),
        .ch_en              (ch_en),
        .frame_words        (frame_words),
        .ingress_fifo_rd_en (ingress_fifo_rd_en),
        .ingress_fifo_out   (ingress_fifo_out),
        .ingress_fifo_empty (ingress_fifo_empty),
        .egress_fifo_din    (egress_fifo_din),
        .egress_fifo_wren   (egress_fifo_wren),
        .egress_fifo_full   (egress_fifo_full),
        .cur_ch             (cur_ch),
        .busy               (busy),
        .frame_done         (frame_done),
        .frame_cnt          (frame_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Ingress FIFOs: endless per-channel sequences, output register updated on pop.
    logic [DW-1:0] fifo_data [N];
    int            fifo_seq  [N];
    logic [N-1:0]  pop_v;

    // Reference model state.
    bit  act_en  [N];
    int  act_len [N];
    int  exp_seq [N];
    int  last_served, exp_ch, exp_left, frames_done, data_in_frame;
    bit  hdr_pending;
    bit  prev_full;
    int  wr_under_full, full_hold, stall_mode, stall_pct, full_pct, cyc;

    always_comb begin
        for (int k = 0; k < N; k++) ingress_fifo_out[k*DW +: DW] = fifo_data[k];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int ch, input int seq);
        return {4'(ch), 12'(seq)};
    endfunction

    function automatic int pick_next();
        int start;
        int c;
        start = (last_served < 0) ? 0 : (last_served + 1) % N;
        for (int i = 0; i < N; i++) begin
            c = (start + i) % N;
            if (act_en[c] && act_len[c] != 0) return c;
        end
        return -1;
    endfunction

    function automatic bit any_qualifies();
        for (int k = 0; k < N; k++) if (act_en[k] && act_len[k] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        last_served   = -1;
        exp_ch        = -1;
        exp_left      = 0;
        frames_done   = 0;
        data_in_frame = 0;
        hdr_pending   = 1'b0;
        prev_full     = 1'b0;
        wr_under_full = 0;
        for (int k = 0; k < N; k++) exp_seq[k] = fifo_seq[k];
    endtask

    // One clock: check outputs at negedge, then drive the next cycle's inputs just after posedge.
    task automatic step();
        @(negedge init_clk);
        cyc++;
        check_eq("rd_gate", 64'(ingress_fifo_rd_en & (ingress_fifo_empty | {N{egress_fifo_full}})), 64'(0));
        check_eq("rd_onehot", 64'($countones(ingress_fifo_rd_en) > 1), 64'(0));
        pop_v = ingress_fifo_rd_en;
        if (egress_fifo_wren) begin
            if (exp_ch < 0) begin
                exp_ch = pick_next();
                if (exp_ch < 0) begin
                    check_eq("unexpected_write", 64'(egress_fifo_wren), 64'(0));
                end else begin
                    exp_left      = act_len[exp_ch];
                    hdr_pending   = HDR_EN;
                    last_served   = exp_ch;
                    data_in_frame = 0;
                end
            end
            if (exp_ch >= 0) begin
                check_eq("cur_ch", 64'(cur_ch), 64'(exp_ch));
                check_eq("busy_in_frame", 64'(busy), 64'(1));
                if (hdr_pending) begin
                    check_eq("hdr_word", 64'(egress_fifo_din), 64'({8'hA5, 8'(exp_ch)}));
                    check_eq("hdr_done", 64'(frame_done), 64'(0));
                    hdr_pending = 1'b0;
                end else begin
                    check_eq("data", 64'(egress_fifo_din), 64'(word_of(exp_ch, exp_seq[exp_ch])));
                    exp_seq[exp_ch]++;
                    exp_left--;
                    data_in_frame++;
                    check_eq("frame_done", 64'(frame_done), 64'(exp_left == 0));
                    if (exp_left == 0) begin
                        frames_done++;
                        check_eq("frame_cnt", 64'(frame_cnt), 64'(frames_done));
                        exp_ch = -1;
                    end
                end
            end
            if (prev_full) wr_under_full++;
            check_eq("full_slip", 64'(wr_under_full > 2), 64'(0));
        end else begin
            check_eq("idle_out", 64'({egress_fifo_din, frame_done}), 64'(0));
        end
        if (!egress_fifo_full) wr_under_full = 0;
        prev_full = egress_fifo_full;

        @(posedge init_clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (pop_v[k]) begin
                fifo_data[k] = word_of(k, fifo_seq[k]);
                fifo_seq[k]++;
            end
        end
        case (stall_mode)
            1: for (int k = 0; k < N; k++) ingress_fifo_empty[k] = ($urandom_range(99) < stall_pct);
            2: ingress_fifo_empty = (((cyc / 2) % 2) == 1) ? '1 : '0;
            default: ingress_fifo_empty = '0;
        endcase
        if (full_hold > 0) begin
            egress_fifo_full = 1'b1;
            full_hold--;
        end else begin
            egress_fifo_full = ($urandom_range(99) < full_pct);
        end
    endtask

    task automatic apply_cfg(input logic [N-1:0] en, input logic [N*LEN_W-1:0] lens);
        ch_en       = en;
        frame_words = lens;
        for (int k = 0; k < N; k++) begin
            act_en[k]  = en[k];
            act_len[k] = int'(lens[k*LEN_W +: LEN_W]);
        end
    endtask

    function automatic logic [N*LEN_W-1:0] uniform_len(input int v);
        logic [N*LEN_W-1:0] r;
        for (int k = 0; k < N; k++) r[k*LEN_W +: LEN_W] = LEN_W'(v);
        return r;
    endfunction

    task automatic run_frames(input int n, input int budget);
        int target;
        int c;
        target = frames_done + n;
        c = 0;
        while (frames_done < target && c < budget) begin
            step();
            c++;
        end
        check_eq("frames_reached", 64'(frames_done >= target), 64'(1));
    endtask

    // Disable and scramble config mid-frame; the running frame must still complete.
    task automatic go_idle();
        int quiet;
        int c;
        c = 0;
        if (any_qualifies()) begin
            while (exp_ch < 0 && c < 100) begin
                step();
                c++;
            end
        end
        ch_en = '0;
        for (int k = 0; k < N; k++) frame_words[k*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 9));
        quiet = 0;
        c = 0;
        while (quiet < 4 && c < 400) begin
            step();
            c++;
            quiet = (busy == 1'b0 && exp_ch < 0) ? quiet + 1 : 0;
        end
        check_eq("drain_idle", 64'(quiet >= 4), 64'(1));
        if (last_served >= 0) check_eq("cur_ch_hold", 64'(cur_ch), 64'(last_served));
    endtask

    initial begin
        logic [N*LEN_W-1:0] lens;
        logic [N-1:0]       en;
        int                 c;

        reset_n_i          = 1'b1;
        ch_en              = '0;
        frame_words        = '0;
        ingress_fifo_empty = '0;
        egress_fifo_full   = 1'b0;
        stall_mode = 0; stall_pct = 0; full_pct = 0; full_hold = 0; cyc = 0;
        for (int k = 0; k < N; k++) begin
            fifo_seq[k]  = 0;
            fifo_data[k] = '0;
            act_en[k]    = 1'b0;
            act_len[k]   = 0;
        end
        model_reset();
        #1 reset_n_i = 1'b0;
        #1;
        check_eq("rst_rd_en", 64'(ingress_fifo_rd_en), 64'(0));
        check_eq("rst_wren", 64'(egress_fifo_wren), 64'(0));
        check_eq("rst_din", 64'(egress_fifo_din), 64'(0));
        check_eq("rst_cur_ch", 64'(cur_ch), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        repeat (2) step();
        reset_n_i = 1'b1;

        // All channels, 4 words, no back-pressure: channel order 0..5.
        apply_cfg('1, uniform_len(4));
        run_frames(6, 300);
        check_eq("cnt_after_six", 64'(frame_cnt), 64'(6));
        go_idle();

        // Sparse enable with random ingress stalls.
        apply_cfg(6'b100100, uniform_len(3));
        stall_mode = 1; stall_pct = 30;
        run_frames(6, 600);
        go_idle();

        // Zero-length channel 1, toggling empty, long egress full mid-stream.
        lens = uniform_len(2);
        lens[1*LEN_W +: LEN_W] = '0;
        apply_cfg('1, lens);
        stall_mode = 2;
        repeat (7) step();
        full_hold = 10;
        run_frames(5, 600);
        go_idle();

        for (int p = 0; p < 7; p++) begin
            en = N'($urandom);
            for (int k = 0; k < N; k++) lens[k*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 7));
            apply_cfg(en, lens);
            stall_mode = int'($urandom_range(0, 2));
            stall_pct  = int'($urandom_range(0, 50));
            full_pct   = int'($urandom_range(0, 40));
            if (any_qualifies()) run_frames(6, 1500);
            else repeat (20) step();
            go_idle();
        end

        // Reset in the middle of a 5-word frame on channel 3.
        stall_mode = 0; full_pct = 0;
        apply_cfg(6'b001000, uniform_len(5));
        c = 0;
        while (!(exp_ch == 3 && data_in_frame == 3) && c < 200) begin
            step();
            c++;
        end
        check_eq("reached_word3", 64'(data_in_frame), 64'(3));
        #2 reset_n_i = 1'b0;
        #1;
        check_eq("mid_rst_rd_en", 64'(ingress_fifo_rd_en), 64'(0));
        check_eq("mid_rst_wren", 64'(egress_fifo_wren), 64'(0));
        check_eq("mid_rst_din", 64'(egress_fifo_din), 64'(0));
        check_eq("mid_rst_cur_ch", 64'(cur_ch), 64'(0));
        check_eq("mid_rst_busy", 64'(busy), 64'(0));
        check_eq("mid_rst_done", 64'(frame_done), 64'(0));
        check_eq("mid_rst_cnt", 64'(frame_cnt), 64'(0));
        model_reset();
        apply_cfg('1, uniform_len(2));
        repeat (3) step();
        reset_n_i = 1'b1;
        run_frames(3, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
